// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - two-requester round-robin front end for a shared ULA
module ula_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter bit FORBID_BREAK  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [3:0]       ula_op,
  input  logic [WIDTH-1:0] ula_s,
  input  logic             ula_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_z,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [3:0] OP_BREAK    = 4'b1111;
  localparam logic [3:0] OP_NOP      = 4'b0000;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic [3:0]       cnt;
  logic             gnt;
  logic             accept;
  logic             reject;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;

  // Pick the requester to serve: a lone valid wins, a tie goes to the RR pointer
  always_comb begin
    gnt = ptr;
    if (req_valid == 2'b01) begin
      gnt = 1'b0;
    end else if (req_valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

  assign accept = (state == IDLE) && req_valid[gnt];
  assign sel_a  = gnt ? req1_a  : req0_a;
  assign sel_b  = gnt ? req1_b  : req0_b;
  assign sel_op = gnt ? req1_op : req0_op;
  assign reject = FORBID_BREAK && (sel_op == OP_BREAK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; a rejected opcode skips the ULA and answers at once
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = reject ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is one-hot on the granted requester, and only while idle
  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      req_ready[gnt] = 1'b1;
    end
  end

  // Operand latching, settle countdown and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      cnt       <= 4'd0;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_op    <= OP_NOP;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_s     <= '0;
      rsp_z     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr    <= ~gnt;
            rsp_id <= gnt;
            ula_a  <= sel_a;
            ula_b  <= sel_b;
            if (reject) begin
              // Never let the break opcode reach the ULA
              ula_op    <= OP_NOP;
              cnt       <= 4'd0;
              rsp_s     <= '0;
              rsp_z     <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              ula_op <= sel_op;
              cnt    <= SETTLE_INIT;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_s     <= ula_s;
            rsp_z     <= ula_z;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - self-checking bench for ula_arbiter with a behavioural ULA
module tb_ula_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [1:0]   req_valid, req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] ula_a, ula_b, ula_s;
  logic [3:0]   ula_op;
  logic         ula_z;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_err;
  logic [W-1:0] rsp_s;

  logic [1:0]   d4_req_valid, d4_req_ready;
  logic [W-1:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
  logic [3:0]   d4_req0_op, d4_req1_op;
  logic [W-1:0] d4_ula_a, d4_ula_b, d4_ula_s;
  logic [3:0]   d4_ula_op;
  logic         d4_ula_z;
  logic         d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_z, d4_rsp_err;
  logic [W-1:0] d4_rsp_s;

  int checks = 0;
  int errors = 0;

  // Behavioural ULA: returns {zero, result}
  function automatic logic [W:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] op);
    logic [W-1:0] s;
    case (op)
      4'b0000: s = a & b;
      4'b0001: s = a | b;
      4'b0010: s = a + b;
      4'b0110: s = a - b;
      4'b0111: s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: s = ~(a | b);
      default: s = '0;
    endcase
    return {(s == '0), s};
  endfunction

  assign {ula_z, ula_s}       = ula_f(ula_a, ula_b, ula_op);
  assign {d4_ula_z, d4_ula_s} = ula_f(d4_ula_a, d4_ula_b, d4_ula_op);

  ula_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1), .FORBID_BREAK(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_s(ula_s), .ula_z(ula_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_err(rsp_err)
  );

  ula_arbiter #(.WIDTH(W), .SETTLE_CYCLES(4), .FORBID_BREAK(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req0_op(d4_req0_op),
    .req1_a(d4_req1_a), .req1_b(d4_req1_b), .req1_op(d4_req1_op),
    .ula_a(d4_ula_a), .ula_b(d4_ula_b), .ula_op(d4_ula_op), .ula_s(d4_ula_s), .ula_z(d4_ula_z),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id),
    .rsp_s(d4_rsp_s), .rsp_z(d4_rsp_z), .rsp_err(d4_rsp_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // The break opcode must never be presented to either ULA
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (ula_op === 4'b1111 || d4_ula_op === 4'b1111) begin
        errors++;
        $display("FAIL ula_op_break: got %b/%b expected not 1111", ula_op, d4_ula_op);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    d4_req_valid = 2'b00;
    rsp_ready = 1'b1;
    d4_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] a0, b0;
    logic [3:0]   op0;
    logic [W-1:0] a1, b1;
    logic [3:0]   op1;
    logic         exp_id;
    logic [W-1:0] exp_s;
    logic         exp_z;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic apply_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    req_valid = v.valid;
    req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    rsp_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_ready", idx), 128'(req_ready), 128'(v.exp_id ? 2'b10 : 2'b01));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("vec%0d_timeout", idx), 128'(n < 20), 128'(1'b1));
    if (!v.exp_err) check($sformatf("vec%0d_latency", idx), 128'(n), 128'(1));
    check($sformatf("vec%0d_rsp", idx), 128'({rsp_id, rsp_err, rsp_z, rsp_s}),
          128'({v.exp_id, v.exp_err, v.exp_z, v.exp_s}));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d_done", idx), 128'(rsp_valid), 128'(1'b0));
  endtask

  logic [3:0] ops[7];

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    int acc_cyc[8];
    logic ids[8];
    int na, nr, cyc;
    bit [1:0] pend_v;
    logic [W-1:0] pa[2], pb[2];
    logic [3:0] pop[2];
    bit outst, brk, m_ptr, do_acc, do_hs, e_id, e_z, e_err;
    logic [W-1:0] e_s;
    int acc, k, gsel;
    logic [1:0] exp_ready;

    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1111;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    d4_req0_a = '0; d4_req0_b = '0; d4_req0_op = '0;
    d4_req1_a = '0; d4_req1_b = '0; d4_req1_op = '0;

    vecs[0] = '{2'b11, 32'd3, 32'd3, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b0, 32'd0, 1'b1, 1'b0};
    vecs[1] = '{2'b11, 32'd3, 32'd3, 4'b0110, 32'hF0, 32'h0F, 4'b0001, 1'b1, 32'hFF, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 32'd5, 32'd7, 4'b0010, 32'd9, 32'd9, 4'b0010, 1'b0, 32'd12, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 32'd5, 32'd7, 4'b0010, 32'd1, 32'd2, 4'b1111, 1'b1, 32'd0, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 32'd0, 32'd0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 32'd1, 32'd2, 4'b0111,
                1'b0, 32'h0F00_0F00, 1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    check("reset_outputs", 128'({req_ready, ula_a, ula_b, ula_op, rsp_valid, rsp_id, rsp_s, rsp_z, rsp_err}), 128'(0));
    check("reset_outputs_d4", 128'({d4_req_ready, d4_ula_a, d4_ula_b, d4_ula_op, d4_rsp_valid,
                                     d4_rsp_id, d4_rsp_s, d4_rsp_z, d4_rsp_err}), 128'(0));

    // Directed vectors (round-robin, single-valid priority, break rejection)
    for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

    // Both requesters held valid: alternate ids, accepts 3 cycles apart
    do_reset();
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010;
    req1_a = 32'd2; req1_b = 32'd3; req1_op = 4'b0001;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    na = 0; nr = 0; cyc = 0;
    while (nr < 8 && cyc < 100) begin
      #1;
      if ((req_valid & req_ready) != 2'b00 && na < 8) begin
        acc_cyc[na] = cyc;
        na++;
      end
      if (rsp_valid && rsp_ready) begin
        ids[nr] = rsp_id;
        check($sformatf("rr_s%0d", nr), 128'(rsp_s), 128'(rsp_id ? 32'd3 : 32'd2));
        nr++;
      end
      if (nr < 8) begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 2'b00;
    check("rr_count", 128'(nr), 128'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < nr) check($sformatf("rr_id%0d", i), 128'(ids[i]), 128'(i % 2));
      if (i > 0 && i < na) check($sformatf("rr_gap%0d", i), 128'(acc_cyc[i] - acc_cyc[i-1]), 128'(3));
    end
    @(posedge clk);

    // Response backpressure: held stable, no grants while waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_a = 32'd10; req0_b = 32'd20; req0_op = 4'b0010;
    req1_a = 32'h3;  req1_b = 32'h4;  req1_op = 4'b0001;
    req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_timeout", 128'(n < 20), 128'(1'b1));
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_hold%0d", i), 128'({rsp_valid, rsp_id, rsp_z, rsp_s, req_ready}),
            128'({1'b1, 1'b0, 1'b0, 32'd30, 2'b00}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_release", 128'({rsp_valid, req_ready}), 128'({1'b0, 2'b10}));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_req1", 128'({rsp_id, rsp_err, rsp_s}), 128'({1'b1, 1'b0, 32'h7}));
    @(posedge clk);

    // SETTLE_CYCLES=4 latency
    do_reset();
    @(negedge clk);
    d4_rsp_ready = 1'b0;
    d4_req1_a = 32'd9; d4_req1_b = 32'd4; d4_req1_op = 4'b0110;
    d4_req_valid = 2'b10;
    #1;
    check("d4_ready", 128'(d4_req_ready), 128'(2'b10));
    @(posedge clk);
    @(negedge clk);
    d4_req_valid = 2'b00;
    n = 0;
    while (!d4_rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("d4_latency", 128'(n), 128'(4));
    check("d4_rsp", 128'({d4_rsp_id, d4_rsp_err, d4_rsp_z, d4_rsp_s}), 128'({1'b1, 1'b0, 1'b0, 32'd5}));
    d4_rsp_ready = 1'b1;
    @(posedge clk);

    // Asynchronous reset in the middle of EXEC on both instances
    @(negedge clk);
    req0_a = 32'd7; req0_b = 32'd8; req0_op = 4'b0010; req_valid = 2'b01;
    d4_req0_a = 32'd7; d4_req0_b = 32'd8; d4_req0_op = 4'b0010; d4_req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    d4_req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", 128'({req_ready, ula_a, ula_b, ula_op, rsp_valid, rsp_id, rsp_s, rsp_z, rsp_err}), 128'(0));
    check("rst_async_d4", 128'({d4_req_ready, d4_ula_a, d4_ula_b, d4_ula_op, d4_rsp_valid,
                                 d4_rsp_id, d4_rsp_s, d4_rsp_z, d4_rsp_err}), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || d4_rsp_valid) n++;
    end
    check("rst_no_rsp", 128'(n), 128'(0));
    req_valid = 2'b11;
    d4_req_valid = 2'b11;
    #1;
    check("rst_ptr", 128'({req_ready, d4_req_ready}), 128'({2'b01, 2'b01}));
    req_valid = 2'b00;
    d4_req_valid = 2'b00;

    // Randomized traffic against a transaction-level reference model
    do_reset();
    pend_v = 2'b00; outst = 1'b0; brk = 1'b0; m_ptr = 1'b0;
    do_acc = 1'b0; do_hs = 1'b0; acc = 0; k = 0; gsel = 0;
    e_id = 1'b0; e_z = 1'b0; e_err = 1'b0; e_s = '0;
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      k++;
      if (do_hs) outst = 1'b0;
      if (do_acc) begin
        outst = 1'b1;
        acc = k;
        pend_v[gsel] = 1'b0;
        m_ptr = (gsel == 0);
        e_id = (gsel == 1);
        brk = (pop[gsel] == 4'b1111);
        if (brk) begin
          e_s = '0; e_z = 1'b0; e_err = 1'b1;
        end else begin
          {e_z, e_s} = ula_f(pa[gsel], pb[gsel], pop[gsel]);
          e_err = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
          pend_v[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
          pop[i] = ops[$urandom_range(0, 6)];
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_valid = pend_v;
      req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
      req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
      #1;
      if (pend_v == 2'b11) gsel = m_ptr ? 1 : 0;
      else gsel = pend_v[1] ? 1 : 0;
      exp_ready = (!outst && pend_v != 2'b00) ? (gsel == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_ready", 128'(req_ready), 128'(exp_ready));
      if (outst) begin
        if (!brk) check("rnd_rvalid", 128'(rsp_valid), 128'(k >= acc + 1));
        else if (k >= acc + 1) check("rnd_rvalid_err", 128'(rsp_valid), 128'(1'b1));
        if (rsp_valid) check("rnd_rsp", 128'({rsp_id, rsp_err, rsp_z, rsp_s}),
                             128'({e_id, e_err, e_z, e_s}));
      end else begin
        check("rnd_idle_rvalid", 128'(rsp_valid), 128'(1'b0));
      end
      do_acc = !outst && (pend_v != 2'b00);
      do_hs = outst && rsp_valid && rsp_ready;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
